// File: rtl/gpio_edge_capture.sv
// gpio_edge_capture: GPIO pin synchroniser, debouncer and sticky edge capture
// with a 32-byte memory-mapped status window and a level interrupt.
// Build option: define GPIO_DEBOUNCE_EN to enable the per-pin debounce counters;
// without it pin_level is simply the synchronised pin registered once more.
module gpio_edge_capture #(
    parameter logic [31:0] BASE_ADDR       = 32'h80000100,
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    inout  wire  [63:0]      data_bi,
    input  logic [31:0]      address,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic [1:0]       size,
    output logic [WIDTH-1:0] pin_level,
    output logic             irq
);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] en_rise;
    logic [WIDTH-1:0] en_fall;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [63:0]      rdata;
    logic             hit;
    logic             wr;
    logic             rd;
    logic [1:0]       sel;
    logic [100:0]     unused_bits;

    assign hit = (address[31:5] == BASE_ADDR[31:5]);
    assign sel = address[4:3];
    assign wr  = mem_write && hit;
    assign rd  = mem_read && !mem_write && hit;

    // size and the byte offset are accepted but carry no meaning here
    assign unused_bits = {size, address[2:0], data_bi, 32'(DEBOUNCE_CYCLES)};

    // two-flop synchroniser on the raw pins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync   <= '0;
        end else begin
            sync_a <= pins;
            sync   <= sync_a;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] cnt      [WIDTH];
    logic [15:0] cnt_next [WIDTH];

    // accept a new level once it has differed for DEBOUNCE_CYCLES edges
    always_comb begin
        level_next = level;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync[i] != level[i]) begin
                if (cnt[i] == 16'(DEBOUNCE_CYCLES - 1))
                    level_next[i] = sync[i];
                else
                    cnt_next[i] = cnt[i] + 16'd1;
            end
        end
    end

    // debounce counter state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++)
                cnt[i] <= cnt_next[i];
        end
    end
`else
    // no filtering: the clean level is the synchronised pin one edge later
    always_comb begin
        level_next = sync;
    end
`endif

    // clean level register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            level <= '0;
        else
            level <= level_next;
    end

    assign pin_level = level;

    // edge detection is taken from the level about to be registered so flags
    // set on the same edge the level changes
    always_comb begin
        rise_set = level_next & ~level;
        fall_set = level & ~level_next;
        rise_clr = (wr && sel == 2'd1) ? data_bi[WIDTH-1:0] : '0;
        fall_clr = (wr && sel == 2'd2) ? data_bi[WIDTH-1:0] : '0;
    end

    // sticky flags (set beats clear), enables and registered interrupt
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise    <= '0;
            fall    <= '0;
            en_rise <= '0;
            en_fall <= '0;
            irq     <= 1'b0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (wr && sel == 2'd3) begin
                en_rise <= data_bi[WIDTH-1:0];
                en_fall <= data_bi[2*WIDTH-1:WIDTH];
            end
            irq <= |((rise & en_rise) | (fall & en_fall));
        end
    end

    // read mux from current register state
    always_comb begin
        rdata = '0;
        case (sel)
            2'd0: rdata[WIDTH-1:0]   = level;
            2'd1: rdata[WIDTH-1:0]   = rise;
            2'd2: rdata[WIDTH-1:0]   = fall;
            default: rdata[2*WIDTH-1:0] = {en_fall, en_rise};
        endcase
    end

    assign data_bi = rd ? rdata : 64'bz;

endmodule
